// File: rtl/toggle_window_monitor.sv
// Switching-activity monitor: counts output toggles and high cycles over a programmed window.
// Optional input-vector flip counting is enabled with TOGGLE_MON_INPUT_ACTIVITY_EN.
//
// state  | meaning
// S_IDLE | waiting for start; results of last window held
// S_RUN  | one sample of sig_in (and vec_in) per cycle
// S_DONE | single-cycle done pulse, results valid
module toggle_window_monitor #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             sig_in,
    input  logic [3:0]       vec_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             sat,
    output logic [CNT_W-1:0] in_toggle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] sample_cnt;
    logic [WIN_W-1:0] sample_cnt_inc;
    logic             prev_sig;
    logic             have_prev;
    logic             start_acc;
    logic             sampling;
    logic             tog_inc;
    logic             sat_in;

    assign start_acc      = (state == S_IDLE) && start;
    assign sampling       = (state == S_RUN);
    assign sample_cnt_inc = sample_cnt + 1'b1;
    assign tog_inc        = have_prev && (sig_in != prev_sig);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (win_len == '0) ? S_DONE : S_RUN;
            S_RUN:  if (sample_cnt_inc == win_len_q) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            win_len_q  <= '0;
            sample_cnt <= '0;
            prev_sig   <= 1'b0;
            have_prev  <= 1'b0;
            toggle_cnt <= '0;
            high_cnt   <= '0;
            sat        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                win_len_q  <= win_len;
                sample_cnt <= '0;
                prev_sig   <= 1'b0;
                have_prev  <= 1'b0;
                toggle_cnt <= '0;
                high_cnt   <= '0;
                sat        <= 1'b0;
            end else if (sampling) begin
                sample_cnt <= sample_cnt_inc;
                prev_sig   <= sig_in;
                have_prev  <= 1'b1;
                // Counters pin at max; sat records the increment that was lost
                if (tog_inc) begin
                    if (toggle_cnt == CNT_MAX) sat <= 1'b1;
                    else                       toggle_cnt <= toggle_cnt + 1'b1;
                end
                if (sig_in) begin
                    if (high_cnt == CNT_MAX) sat <= 1'b1;
                    else                     high_cnt <= high_cnt + 1'b1;
                end
                if (sat_in) sat <= 1'b1;
            end
        end
    end

`ifdef TOGGLE_MON_INPUT_ACTIVITY_EN
    logic [3:0]     prev_vec;
    logic [3:0]     vec_diff;
    logic [2:0]     vec_flips;
    logic [CNT_W:0] in_tog_sum;

    assign vec_diff   = have_prev ? (vec_in ^ prev_vec) : 4'b0000;
    assign vec_flips  = {2'b00, vec_diff[0]} + {2'b00, vec_diff[1]}
                      + {2'b00, vec_diff[2]} + {2'b00, vec_diff[3]};
    assign in_tog_sum = {1'b0, in_toggle_cnt} + {{(CNT_W-2){1'b0}}, vec_flips};
    assign sat_in     = sampling && in_tog_sum[CNT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_vec      <= 4'b0000;
            in_toggle_cnt <= '0;
        end else if (start_acc) begin
            prev_vec      <= 4'b0000;
            in_toggle_cnt <= '0;
        end else if (sampling) begin
            prev_vec      <= vec_in;
            in_toggle_cnt <= in_tog_sum[CNT_W] ? CNT_MAX : in_tog_sum[CNT_W-1:0];
        end
    end
`else
    logic unused_vec;
    assign unused_vec    = ^vec_in;
    assign sat_in        = 1'b0;
    assign in_toggle_cnt = '0;
`endif

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_toggle_window_monitor.sv
// Directed bench for toggle_window_monitor: a 16-bit instance plus a 4-bit instance for saturation.
module tb_toggle_window_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        sig_in;
    logic [3:0]  vec_in;

    logic        busy, done, sat;
    logic [15:0] toggle_cnt, high_cnt, in_toggle_cnt;
    logic        busy4, done4, sat4;
    logic [3:0]  toggle_cnt4, high_cnt4, in_toggle_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    toggle_window_monitor #(.CNT_W(16), .WIN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .sig_in(sig_in), .vec_in(vec_in), .busy(busy), .done(done),
        .toggle_cnt(toggle_cnt), .high_cnt(high_cnt), .sat(sat),
        .in_toggle_cnt(in_toggle_cnt)
    );

    toggle_window_monitor #(.CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .sig_in(sig_in), .vec_in(vec_in), .busy(busy4), .done(done4),
        .toggle_cnt(toggle_cnt4), .high_cnt(high_cnt4), .sat(sat4),
        .in_toggle_cnt(in_toggle_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; win_len = '0; sig_in = 1'b0; vec_in = '0;
        tick(); tick();
        n_cmp++; if ({busy, done, sat} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b want=000", {busy, done, sat}); end
        n_cmp++; if ({toggle_cnt, high_cnt, in_toggle_cnt} !== 48'd0) begin n_err++; $display("FAIL reset_counts got=%h want=0", {toggle_cnt, high_cnt, in_toggle_cnt}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        accept(16'd10);
        for (int i = 0; i < 3; i++) begin
            sig_in = i[0];
            tick();
        end
        n_cmp++; if (toggle_cnt !== 16'd2 || high_cnt !== 16'd1 || busy !== 1'b1) begin n_err++; $display("FAIL midrun_partial tog=%0d high=%0d busy=%b want 2 1 1", toggle_cnt, high_cnt, busy); end
        rst_n = 1'b0; sig_in = 1'b1;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrun_reset busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (toggle_cnt !== 16'd0 || high_cnt !== 16'd0 || sat !== 1'b0) begin n_err++; $display("FAIL midrun_counts tog=%0d high=%0d sat=%b want 0", toggle_cnt, high_cnt, sat); end
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL midrun_no_done active_cycles=%0d want=0", done_seen); end
    endtask

    task automatic test_alternating();
        int bad;
        accept(16'd8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            sig_in = i[0];
            tick();
            if (i < 7 && (busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL alt_busy_phase bad_cycles=%0d want=0", bad); end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL alt_done done=%b busy=%b want 1 0", done, busy); end
        n_cmp++; if (toggle_cnt !== 16'd7 || high_cnt !== 16'd4 || sat !== 1'b0) begin n_err++; $display("FAIL alt_counts tog=%0d high=%0d sat=%b want 7 4 0", toggle_cnt, high_cnt, sat); end
        sig_in = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b0 || toggle_cnt !== 16'd7 || high_cnt !== 16'd4) begin n_err++; $display("FAIL alt_hold done=%b tog=%0d high=%0d want 0 7 4", done, toggle_cnt, high_cnt); end
    endtask

    task automatic test_constant_and_zero();
        accept(16'd5);
        sig_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (done !== 1'b1 || toggle_cnt !== 16'd0 || high_cnt !== 16'd5) begin n_err++; $display("FAIL const_counts done=%b tog=%0d high=%0d want 1 0 5", done, toggle_cnt, high_cnt); end
        tick();
        accept(16'd0);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done done=%b busy=%b want 1 0", done, busy); end
        n_cmp++; if (toggle_cnt !== 16'd0 || high_cnt !== 16'd0 || sat !== 1'b0) begin n_err++; $display("FAIL zero_counts tog=%0d high=%0d sat=%b want 0", toggle_cnt, high_cnt, sat); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_one_cycle done=%b want=0", done); end
        accept(16'd1);
        sig_in = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b1 || toggle_cnt !== 16'd0 || high_cnt !== 16'd1) begin n_err++; $display("FAIL len1 done=%b tog=%0d high=%0d want 1 0 1", done, toggle_cnt, high_cnt); end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [3:0] pat;
        pat = 4'b0011;
        accept(16'd4);
        for (int i = 0; i < 4; i++) begin
            sig_in  = pat[i];
            start   = (i == 1);
            win_len = 16'd2;
            tick();
        end
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || toggle_cnt !== 16'd1 || high_cnt !== 16'd2) begin n_err++; $display("FAIL ign_run done=%b tog=%0d high=%0d want 1 1 2", done, toggle_cnt, high_cnt); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || toggle_cnt !== 16'd1 || high_cnt !== 16'd2) begin n_err++; $display("FAIL ign_done busy=%b done=%b tog=%0d high=%0d want 0 0 1 2", busy, done, toggle_cnt, high_cnt); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_stays_idle busy=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat;
        start = 1'b1; win_len = 16'd3; sig_in = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (done !== 1'b1 || high_cnt !== 16'd3 || toggle_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_first done=%b tog=%0d high=%0d want 1 0 3", done, toggle_cnt, high_cnt); end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done); end
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || high_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_rearm busy=%b high=%0d want 1 0", busy, high_cnt); end
        pat = 3'b101;
        for (int i = 0; i < 3; i++) begin
            sig_in = pat[i];
            tick();
        end
        n_cmp++; if (done !== 1'b1 || toggle_cnt !== 16'd2 || high_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_second done=%b tog=%0d high=%0d want 1 2 2", done, toggle_cnt, high_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        accept(16'd40);
        n_cmp++; if (sat4 !== 1'b0 || busy4 !== 1'b1) begin n_err++; $display("FAIL sat_start sat4=%b busy4=%b want 0 1", sat4, busy4); end
        for (int i = 0; i < 40; i++) begin
            sig_in = i[0];
            tick();
        end
        n_cmp++; if (done4 !== 1'b1 || toggle_cnt4 !== 4'd15 || high_cnt4 !== 4'd15 || sat4 !== 1'b1) begin n_err++; $display("FAIL sat_narrow done=%b tog=%0d high=%0d sat=%b want 1 15 15 1", done4, toggle_cnt4, high_cnt4, sat4); end
        n_cmp++; if (toggle_cnt !== 16'd39 || high_cnt !== 16'd20 || sat !== 1'b0) begin n_err++; $display("FAIL sat_wide tog=%0d high=%0d sat=%b want 39 20 0", toggle_cnt, high_cnt, sat); end
        tick();
        accept(16'd3);
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (done4 !== 1'b1 || toggle_cnt4 !== 4'd0 || high_cnt4 !== 4'd0 || sat4 !== 1'b0) begin n_err++; $display("FAIL sat_clear done=%b tog=%0d high=%0d sat=%b want 1 0 0 0", done4, toggle_cnt4, high_cnt4, sat4); end
        tick();
    endtask

    task automatic test_input_activity();
        logic [15:0] vecs;
        logic [15:0] exp_cnt;
`ifdef TOGGLE_MON_INPUT_ACTIVITY_EN
        exp_cnt = 16'd9;
`else
        exp_cnt = 16'd0;
`endif
        vecs = 16'h1EF0;
        accept(16'd4);
        sig_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec_in = vecs[i*4 +: 4];
            tick();
        end
        vec_in = 4'b0000;
        n_cmp++; if (done !== 1'b1 || in_toggle_cnt !== exp_cnt) begin n_err++; $display("FAIL vec_cnt done=%b got=%0d want=%0d", done, in_toggle_cnt, exp_cnt); end
        n_cmp++; if (in_toggle_cnt4 !== exp_cnt[3:0] || sat4 !== 1'b0) begin n_err++; $display("FAIL vec_cnt_narrow got=%0d sat=%b want=%0d 0", in_toggle_cnt4, sat4, exp_cnt[3:0]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_alternating();
        test_constant_and_zero();
        test_start_ignored();
        test_back_to_back();
        test_saturation();
        test_input_activity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
